// File: rtl/dif_run_ctrl.sv
// rtl/dif_run_ctrl.sv - DIF run-control FSM: acquisition, conversion, per-chip readout, SC and HV
// Moore outputs are registered from the next-state decode; acq is additionally gated by acquisition.
module dif_run_ctrl #(
    parameter int N_CHIP   = 4,
    parameter int SAT_MODE = 0,
    parameter int CONV_MIN = 4,
    parameter int TMO_W    = 16,
    parameter int TMO_CYC  = 1000,
    localparam int SEL_W   = (N_CHIP > 1) ? $clog2(N_CHIP) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acquisition,
    input  logic [N_CHIP-1:0] chip_en,
    input  logic [N_CHIP-1:0] chipsat,
    input  logic              sc_req,
    input  logic              sc_done,
    input  logic              hv_config_en,
    input  logic              hv_config_rep_receive,
    input  logic              hv_config_done,
    input  logic              end_readout,
    input  logic              err_clr,
    output logic              idle,
    output logic              acq,
    output logic              conv_n,
    output logic              read,
    output logic [SEL_W-1:0]  read_sel,
    output logic              sc,
    output logic              hv_wr,
    output logic              hv_rd,
    output logic              error,
    output logic [2:0]        err_code
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACQ   = 3'd1,
        S_CONV  = 3'd2,
        S_READ  = 3'd3,
        S_SC    = 3'd4,
        S_HV_WR = 3'd5,
        S_HV_RD = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    localparam bit               TMO_EN   = (TMO_CYC != 0);
    localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TMO_CYC - 1);
    localparam logic [TMO_W-1:0] CONV_LIM = TMO_W'(CONV_MIN - 1);

    state_t            state, state_d;
    logic [N_CHIP-1:0] mask_q, mask_d;
    logic [TMO_W-1:0]  timer, timer_d;
    logic [SEL_W-1:0]  sel_d, first_sel, next_sel;
    logic [2:0]        code_d;
    logic              has_next, sat, tmo, tmr_clr, acq_st;

    assign sat = (SAT_MODE != 0) ? &(chipsat | ~mask_q) : |(chipsat & mask_q);
    assign tmo = TMO_EN && (timer == TMO_LIM);
    assign acq = acq_st & acquisition;

    // Descending scan leaves the lowest qualifying index in each result.
    always_comb begin
        first_sel = '0;
        next_sel  = read_sel;
        has_next  = 1'b0;
        for (int i = N_CHIP - 1; i >= 0; i--) begin
            if (mask_q[i]) first_sel = SEL_W'(i);
            if (mask_q[i] && (i > int'(read_sel))) begin
                next_sel = SEL_W'(i);
                has_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        mask_d  = mask_q;
        sel_d   = read_sel;
        code_d  = err_code;
        tmr_clr = 1'b0;
        case (state)
            S_IDLE: begin
                if (acquisition) begin
                    if (chip_en == '0) begin
                        state_d = S_ERR;
                        code_d  = 3'd1;
                    end else begin
                        state_d = S_ACQ;
                        mask_d  = chip_en;
                    end
                end else if (sc_req) begin
                    state_d = S_SC;
                end else if (hv_config_en) begin
                    state_d = S_HV_WR;
                end
            end
            S_ACQ: if (!acquisition && sat) state_d = S_CONV;
            S_CONV: begin
                if (((chipsat & mask_q) == '0) && (timer >= CONV_LIM)) begin
                    state_d = S_READ;
                    sel_d   = first_sel;
                end else if (tmo) begin
                    state_d = S_ERR;
                    code_d  = 3'd2;
                end
            end
            S_READ: begin
                if (end_readout) begin
                    if (has_next) begin
                        sel_d   = next_sel;
                        tmr_clr = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (tmo) begin
                    state_d = S_ERR;
                    code_d  = 3'd3;
                end
            end
            S_SC: begin
                if (sc_done) state_d = S_IDLE;
                else if (tmo) begin
                    state_d = S_ERR;
                    code_d  = 3'd4;
                end
            end
            S_HV_WR: begin
                if (hv_config_rep_receive) state_d = S_HV_RD;
                else if (tmo) begin
                    state_d = S_ERR;
                    code_d  = 3'd5;
                end
            end
            S_HV_RD: begin
                if (hv_config_done) state_d = S_IDLE;
                else if (tmo) begin
                    state_d = S_ERR;
                    code_d  = 3'd5;
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    state_d = S_IDLE;
                    code_d  = 3'd0;
                end
            end
            default: begin
                state_d = S_ERR;
                code_d  = 3'd7;
            end
        endcase
        if (state_d != state) tmr_clr = 1'b1;
    end

    assign timer_d = tmr_clr ? '0 : ((&timer) ? timer : timer + 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mask_q   <= '0;
            timer    <= '0;
            read_sel <= '0;
            err_code <= 3'd0;
            idle     <= 1'b1;
            acq_st   <= 1'b0;
            conv_n   <= 1'b1;
            read     <= 1'b0;
            sc       <= 1'b0;
            hv_wr    <= 1'b0;
            hv_rd    <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_d;
            mask_q   <= mask_d;
            timer    <= timer_d;
            read_sel <= sel_d;
            err_code <= code_d;
            idle     <= (state_d == S_IDLE);
            acq_st   <= (state_d == S_ACQ);
            conv_n   <= (state_d != S_CONV);
            read     <= (state_d == S_READ);
            sc       <= (state_d == S_SC);
            hv_wr    <= (state_d == S_HV_WR);
            hv_rd    <= (state_d == S_HV_RD);
            error    <= (state_d == S_ERR);
        end
    end

endmodule

// File: tb/tb_dif_run_ctrl.sv
// tb/tb_dif_run_ctrl.sv - directed bench for dif_run_ctrl
// Second instance runs with SAT_MODE=1 on the same inputs.
module tb_dif_run_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       acquisition, sc_req, sc_done, hv_config_en;
    logic       hv_config_rep_receive, hv_config_done, end_readout, err_clr;
    logic [3:0] chip_en, chipsat;

    logic       idle, acq, conv_n, read, sc, hv_wr, hv_rd, error;
    logic [1:0] read_sel;
    logic [2:0] err_code;
    logic       idle1, acq1, conv_n1, read1, sc1, hv_wr1, hv_rd1, error1;
    logic [1:0] read_sel1;
    logic [2:0] err_code1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dif_run_ctrl #(.N_CHIP(4), .SAT_MODE(0), .CONV_MIN(4), .TMO_W(16), .TMO_CYC(100)) u_dut (
        .clk(clk), .rst_n(rst_n), .acquisition(acquisition), .chip_en(chip_en),
        .chipsat(chipsat), .sc_req(sc_req), .sc_done(sc_done), .hv_config_en(hv_config_en),
        .hv_config_rep_receive(hv_config_rep_receive), .hv_config_done(hv_config_done),
        .end_readout(end_readout), .err_clr(err_clr), .idle(idle), .acq(acq),
        .conv_n(conv_n), .read(read), .read_sel(read_sel), .sc(sc), .hv_wr(hv_wr),
        .hv_rd(hv_rd), .error(error), .err_code(err_code)
    );

    dif_run_ctrl #(.N_CHIP(4), .SAT_MODE(1), .CONV_MIN(4), .TMO_W(16), .TMO_CYC(100)) u_dut_all (
        .clk(clk), .rst_n(rst_n), .acquisition(acquisition), .chip_en(chip_en),
        .chipsat(chipsat), .sc_req(sc_req), .sc_done(sc_done), .hv_config_en(hv_config_en),
        .hv_config_rep_receive(hv_config_rep_receive), .hv_config_done(hv_config_done),
        .end_readout(end_readout), .err_clr(err_clr), .idle(idle1), .acq(acq1),
        .conv_n(conv_n1), .read(read1), .read_sel(read_sel1), .sc(sc1), .hv_wr(hv_wr1),
        .hv_rd(hv_rd1), .error(error1), .err_code(err_code1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        acquisition = 1'b0; sc_req = 1'b0; sc_done = 1'b0; hv_config_en = 1'b0;
        hv_config_rep_receive = 1'b0; hv_config_done = 1'b0; end_readout = 1'b0;
        err_clr = 1'b0; chip_en = 4'b0000; chipsat = 4'b0000;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_end_readout();
        end_readout = 1'b1;
        tick();
        end_readout = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({idle, acq, conv_n, read, sc, hv_wr, hv_rd, error} !== 8'b1010_0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp %b", {idle, acq, conv_n, read, sc, hv_wr, hv_rd, error}, 8'b1010_0000);
        end
        checks++;
        if (read_sel !== 2'd0 || err_code !== 3'd0) begin
            errors++;
            $display("FAIL reset_regs got sel=%0d code=%0d exp sel=0 code=0", read_sel, err_code);
        end
    endtask

    task automatic test_t1_readout();
        chip_en = 4'b1011; acquisition = 1'b1; chipsat = 4'b0010;
        tick();
        checks++;
        if (acq !== 1'b1 || idle !== 1'b0) begin
            errors++; $display("FAIL t1_acq got acq=%b idle=%b exp acq=1 idle=0", acq, idle);
        end
        acquisition = 1'b0;
        tick();
        checks++;
        if (conv_n !== 1'b0) begin
            errors++; $display("FAIL t1_conv_enter got conv_n=%b exp 0", conv_n);
        end
        chipsat = 4'b0000;
        repeat (3) tick();
        checks++;
        if (conv_n !== 1'b0 || read !== 1'b0) begin
            errors++; $display("FAIL t1_conv_hold got conv_n=%b read=%b exp conv_n=0 read=0", conv_n, read);
        end
        tick();
        checks++;
        if (read !== 1'b1 || read_sel !== 2'd0 || conv_n !== 1'b1) begin
            errors++; $display("FAIL t1_read0 got read=%b sel=%0d exp read=1 sel=0", read, read_sel);
        end
        pulse_end_readout();
        checks++;
        if (read !== 1'b1 || read_sel !== 2'd1) begin
            errors++; $display("FAIL t1_read1 got read=%b sel=%0d exp read=1 sel=1", read, read_sel);
        end
        pulse_end_readout();
        checks++;
        if (read !== 1'b1 || read_sel !== 2'd3) begin
            errors++; $display("FAIL t1_read3 got read=%b sel=%0d exp read=1 sel=3", read, read_sel);
        end
        pulse_end_readout();
        checks++;
        if (idle !== 1'b1 || read !== 1'b0 || read_sel !== 2'd3) begin
            errors++; $display("FAIL t1_done got idle=%b read=%b sel=%0d exp idle=1 read=0 sel=3", idle, read, read_sel);
        end
    endtask

    task automatic test_t2_sat_all();
        do_reset();
        chip_en = 4'b0011; acquisition = 1'b1;
        tick();
        acquisition = 1'b0; chipsat = 4'b0001;
        repeat (3) tick();
        checks++;
        if (idle1 !== 1'b0 || conv_n1 !== 1'b1 || error1 !== 1'b0) begin
            errors++; $display("FAIL t2_stay_acq got idle=%b conv_n=%b err=%b exp 0 1 0", idle1, conv_n1, error1);
        end
        chipsat = 4'b0011;
        tick();
        checks++;
        if (conv_n1 !== 1'b0) begin
            errors++; $display("FAIL t2_conv got conv_n=%b exp 0", conv_n1);
        end
        do_reset();
    endtask

    task automatic test_t3_empty_mask();
        acquisition = 1'b1; chip_en = 4'b0000;
        tick();
        acquisition = 1'b0;
        checks++;
        if (error !== 1'b1 || err_code !== 3'd1) begin
            errors++; $display("FAIL t3_err got error=%b code=%0d exp error=1 code=1", error, err_code);
        end
        repeat (2) tick();
        checks++;
        if (error !== 1'b1 || err_code !== 3'd1) begin
            errors++; $display("FAIL t3_sticky got error=%b code=%0d exp error=1 code=1", error, err_code);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (idle !== 1'b1 || error !== 1'b0 || err_code !== 3'd0) begin
            errors++; $display("FAIL t3_clear got idle=%b error=%b code=%0d exp 1 0 0", idle, error, err_code);
        end
    endtask

    task automatic test_t4_sc_timeout();
        sc_req = 1'b1;
        tick();
        checks++;
        if (sc !== 1'b1) begin
            errors++; $display("FAIL t4_sc_enter got sc=%b exp 1", sc);
        end
        repeat (99) tick();
        checks++;
        if (sc !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL t4_sc_cycle99 got sc=%b error=%b exp sc=1 error=0", sc, error);
        end
        tick();
        checks++;
        if (error !== 1'b1 || err_code !== 3'd4) begin
            errors++; $display("FAIL t4_sc_tmo got error=%b code=%0d exp error=1 code=4", error, err_code);
        end
        sc_req = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        sc_req = 1'b1;
        tick();
        sc_req = 1'b0;
        repeat (99) tick();
        sc_done = 1'b1;
        tick();
        sc_done = 1'b0;
        checks++;
        if (idle !== 1'b1 || error !== 1'b0 || err_code !== 3'd0) begin
            errors++; $display("FAIL t4_sc_done_edge got idle=%b error=%b code=%0d exp 1 0 0", idle, error, err_code);
        end
    endtask

    task automatic test_conv_timeout();
        chip_en = 4'b0001; acquisition = 1'b1;
        tick();
        acquisition = 1'b0; chipsat = 4'b0001;
        tick();
        repeat (99) tick();
        checks++;
        if (conv_n !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL conv_hold99 got conv_n=%b error=%b exp 0 0", conv_n, error);
        end
        tick();
        checks++;
        if (error !== 1'b1 || err_code !== 3'd2) begin
            errors++; $display("FAIL conv_tmo got error=%b code=%0d exp error=1 code=2", error, err_code);
        end
        chipsat = 4'b0000; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_t5_priority_hv();
        acquisition = 1'b1; sc_req = 1'b1; hv_config_en = 1'b1; chip_en = 4'b0001;
        tick();
        checks++;
        if (acq !== 1'b1 || sc !== 1'b0 || hv_wr !== 1'b0) begin
            errors++; $display("FAIL t5_priority got acq=%b sc=%b hv_wr=%b exp 1 0 0", acq, sc, hv_wr);
        end
        acquisition = 1'b0; sc_req = 1'b0; hv_config_en = 1'b0; chipsat = 4'b0001;
        tick();
        chipsat = 4'b0000;
        repeat (4) tick();
        pulse_end_readout();
        checks++;
        if (idle !== 1'b1) begin
            errors++; $display("FAIL t5_run_done got idle=%b exp 1", idle);
        end
        hv_config_en = 1'b1;
        tick();
        hv_config_en = 1'b0;
        tick();
        checks++;
        if (hv_wr !== 1'b1 || hv_rd !== 1'b0) begin
            errors++; $display("FAIL t5_hv_wr got hv_wr=%b hv_rd=%b exp 1 0", hv_wr, hv_rd);
        end
        hv_config_rep_receive = 1'b1;
        tick();
        hv_config_rep_receive = 1'b0;
        checks++;
        if (hv_rd !== 1'b1 || hv_wr !== 1'b0) begin
            errors++; $display("FAIL t5_hv_rd got hv_wr=%b hv_rd=%b exp 0 1", hv_wr, hv_rd);
        end
        hv_config_done = 1'b1;
        tick();
        hv_config_done = 1'b0;
        checks++;
        if (idle !== 1'b1 || hv_rd !== 1'b0) begin
            errors++; $display("FAIL t5_hv_done got idle=%b hv_rd=%b exp 1 0", idle, hv_rd);
        end
    endtask

    task automatic test_t6_async_reset();
        chip_en = 4'b1011; acquisition = 1'b1;
        tick();
        chip_en = 4'b0100;
        tick();
        acquisition = 1'b0; chipsat = 4'b0010;
        tick();
        chipsat = 4'b0000;
        repeat (4) tick();
        checks++;
        if (read !== 1'b1 || read_sel !== 2'd0) begin
            errors++; $display("FAIL t6_mask_latched got read=%b sel=%0d exp read=1 sel=0", read, read_sel);
        end
        pulse_end_readout();
        checks++;
        if (read_sel !== 2'd1) begin
            errors++; $display("FAIL t6_sel1 got sel=%0d exp 1", read_sel);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (idle !== 1'b1 || read !== 1'b0 || read_sel !== 2'd0 || conv_n !== 1'b1) begin
            errors++; $display("FAIL t6_async got idle=%b read=%b sel=%0d conv_n=%b exp 1 0 0 1", idle, read, read_sel, conv_n);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_t1_readout();
        test_t2_sat_all();
        test_t3_empty_mask();
        test_t4_sc_timeout();
        test_conv_timeout();
        test_t5_priority_hv();
        test_t6_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
